// File: rtl/up_counter.sv
// ----------------------------------------------------------------------------
// up_counter
//
// Parameterised synchronous binary up counter. It counts modulo MAX+1, and it
// also provides a count enable, a synchronous parallel load and a
// terminal-count flag. Tie en high to make it free-run as a timebase.
//
// Parameters:
//   BITS  counter width in bits (1..32)
//   MAX   terminal count value (1..2**BITS-1), default 2**BITS-1
//
// Ports:
//   clk    in   1     clock; all state changes happen on the rising edge
//   reset  in   1     synchronous active-high reset (Q <= 0, wrap <= 0)
//   en     in   1     count enable
//   load   in   1     synchronous parallel load strobe (takes priority over en)
//   d      in   BITS  parallel load value; values above MAX clamp to MAX
//   Q      out  BITS  current count, driven directly from the register
//   tc     out  1     high while Q == MAX (combinational from Q only)
//   wrap   out  1     one-cycle registered pulse after a MAX -> 0 step
//
// Edge priority: reset > load > en > hold.
//
// Optional build macro:
//   UP_COUNTER_SAT_EN  when defined, the counter saturates at MAX instead of
//                      wrapping, and wrap never asserts. Load, reset and tc
//                      behave the same in both builds.
// ----------------------------------------------------------------------------
module up_counter #(
    parameter int unsigned     BITS = 4,
    parameter longint unsigned MAX  = (64'd1 << BITS) - 64'd1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic            load,
    input  logic [BITS-1:0] d,
    output logic [BITS-1:0] Q,
    output logic            tc,
    output logic            wrap
);

    localparam logic [BITS-1:0] MAX_V = BITS'(MAX);

    // When MAX is the largest value the register can hold, no load value can
    // exceed it. The clamp comparator is then omitted.
    localparam bit FULL_RANGE = (MAX == ((64'd1 << BITS) - 64'd1));

    logic [BITS-1:0] q_q;
    logic [BITS-1:0] q_d;
    logic            wrap_q;
    logic            wrap_d;
    logic [BITS-1:0] load_val;
    logic            at_max;

    generate
        if (FULL_RANGE) begin : g_no_clamp
            always_comb begin
                load_val = d;
            end
        end else begin : g_clamp
            always_comb begin
                load_val = (d > MAX_V) ? MAX_V : d;
            end
        end
    endgenerate

    always_comb begin
        at_max = (q_q == MAX_V);
    end

    // Next-state logic: load beats enable, and hold is the default.
    // wrap_d defaults low, so wrap is a single-cycle pulse.
    always_comb begin
        q_d    = q_q;
        wrap_d = 1'b0;
        if (load) begin
            q_d = load_val;
        end else if (en) begin
            if (at_max) begin
`ifdef UP_COUNTER_SAT_EN
                q_d = q_q;
`else
                q_d    = '0;
                wrap_d = 1'b1;
`endif
            end else begin
                q_d = q_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q    <= '0;
            wrap_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            wrap_q <= wrap_d;
        end
    end

    always_comb begin
        Q    = q_q;
        tc   = at_max;
        wrap = wrap_q;
    end

endmodule

// File: tb/tb_up_counter.sv
// ----------------------------------------------------------------------------
// tb_up_counter
//
// Self-checking bench for up_counter. Two instances share one stimulus
// stream: u16 uses BITS=4 and MAX=15 (full range), and u9 uses BITS=4 and
// MAX=9 (clamped modulus). An arithmetic reference model predicts Q, tc and
// wrap for each instance, and a compare process checks both instances on every
// falling edge once reset has been applied. Directed phases add literal
// expectations that pin the model itself.
// ----------------------------------------------------------------------------
module tb_up_counter;

    logic       clk;
    logic       reset;
    logic       en;
    logic       load;
    logic [3:0] d;

    logic [3:0] q16, q9;
    logic       tc16, tc9;
    logic       wrap16, wrap9;

    int checks   = 0;
    int failures = 0;

    up_counter #(.BITS(4), .MAX(15)) u16 (
        .clk  (clk),
        .reset(reset),
        .en   (en),
        .load (load),
        .d    (d),
        .Q    (q16),
        .tc   (tc16),
        .wrap (wrap16)
    );

    up_counter #(.BITS(4), .MAX(9)) u9 (
        .clk  (clk),
        .reset(reset),
        .en   (en),
        .load (load),
        .d    (d),
        .Q    (q9),
        .tc   (tc9),
        .wrap (wrap9)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    int m16 = 0, m9 = 0;
    bit mw16 = 0, mw9 = 0;
    bit model_valid = 0;

    // Returns the next count value for a counter with terminal value mx.
    // Wrap-around is modular arithmetic; saturation is min().
    function automatic int model_next(int q, int mx, bit rst, bit ld, bit e, int dv);
        if (rst)     return 0;
        if (ld)      return (dv > mx) ? mx : dv;
        if (!e)      return q;
`ifdef UP_COUNTER_SAT_EN
        return (q + 1 > mx) ? mx : q + 1;
`else
        return (q + 1) % (mx + 1);
`endif
    endfunction

    // A wrap happened exactly when an enabled, non-load, non-reset step
    // came from the terminal value.
    function automatic bit model_wrap(int q, int mx, bit rst, bit ld, bit e);
`ifdef UP_COUNTER_SAT_EN
        return 1'b0;
`else
        return !rst && !ld && e && (q == mx);
`endif
    endfunction

    always @(posedge clk) begin
        int dv;
        dv   = int'(d);
        mw16 = model_wrap(m16, 15, reset, load, en);
        mw9  = model_wrap(m9, 9, reset, load, en);
        m16  = model_next(m16, 15, reset, load, en, dv);
        m9   = model_next(m9, 9, reset, load, en, dv);
        if (reset) model_valid = 1'b1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: checks both instances on every falling edge.
    always @(negedge clk) begin
        if (model_valid) begin
            chk("u16.Q",    32'(q16),    32'(m16));
            chk("u16.tc",   32'(tc16),   32'(m16 == 15));
            chk("u16.wrap", 32'(wrap16), 32'(mw16));
            chk("u9.Q",     32'(q9),     32'(m9));
            chk("u9.tc",    32'(tc9),    32'(m9 == 9));
            chk("u9.wrap",  32'(wrap9),  32'(mw9));
        end
    end

    // Sets the inputs at a falling edge, then returns at the next falling edge,
    // so exactly one rising edge samples the inputs.
    task automatic step(input bit r, input bit e, input bit l, input logic [3:0] dv);
        reset = r;
        en    = e;
        load  = l;
        d     = dv;
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        en    = 1'b1;
        load  = 1'b0;
        d     = '0;

        // Reset with en high: the first rising edge clears the counter.
        @(negedge clk);
        chk("rst.Q",    32'(q16),    32'd0);
        chk("rst.tc",   32'(tc16),   32'd0);
        chk("rst.wrap", 32'(wrap16), 32'd0);
        step(0, 1, 0, 0); chk("cnt1", 32'(q16), 32'd1);
        step(0, 1, 0, 0); chk("cnt2", 32'(q16), 32'd2);
        step(0, 1, 0, 0); chk("cnt3", 32'(q16), 32'd3);

        // Free-run to the terminal value and across it.
        step(1, 1, 0, 0);
        for (int i = 0; i < 9; i++) step(0, 1, 0, 0);
        chk("u9.at9.Q",  32'(q9),  32'd9);
        chk("u9.at9.tc", 32'(tc9), 32'd1);
        for (int i = 0; i < 6; i++) step(0, 1, 0, 0);
        chk("u16.at15.Q",  32'(q16),  32'd15);
        chk("u16.at15.tc", 32'(tc16), 32'd1);
        step(0, 1, 0, 0);
`ifdef UP_COUNTER_SAT_EN
        chk("sat.Q",    32'(q16),    32'd15);
        chk("sat.wrap", 32'(wrap16), 32'd0);
`else
        chk("wrap.Q",    32'(q16),    32'd0);
        chk("wrap.pulse", 32'(wrap16), 32'd1);
`endif
        step(0, 1, 0, 0);
        chk("wrap.once", 32'(wrap16), 32'd0);

        // Enable gating at Q=7.
        step(1, 0, 0, 0);
        for (int i = 0; i < 7; i++) step(0, 1, 0, 0);
        chk("gate.Q7", 32'(q16), 32'd7);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
        chk("gate.hold", 32'(q16), 32'd7);
        step(0, 1, 0, 0);
        chk("gate.resume", 32'(q16), 32'd8);

        // Load beats enable, and values above MAX are clamped.
        step(0, 1, 1, 4'd12);
        chk("load.u16",    32'(q16), 32'd12);
        chk("load.u9.clamp", 32'(q9), 32'd9);
        chk("load.u9.tc",  32'(tc9), 32'd1);
        step(1, 1, 1, 4'd12);
        chk("load+rst.u16", 32'(q16), 32'd0);
        chk("load+rst.u9",  32'(q9),  32'd0);

        // Mid-run reset at Q=5.
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0);
        chk("mid.Q5", 32'(q16), 32'd5);
        step(1, 1, 0, 0);
        chk("mid.rst", 32'(q16), 32'd0);
        step(0, 1, 0, 0);
        chk("mid.resume", 32'(q16), 32'd1);

        // Randomised traffic; the compare process checks every cycle.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 49) == 0,
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 7) == 0,
                 4'($urandom_range(0, 15)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
